// File: rtl/multi_mode_shift_unit_pkg.sv
// Shared types for the multi-mode shift unit.
// Shift modes and control FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_ASR = 2'b00,
    SH_LSR = 2'b01,
    SH_LSL = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/multi_mode_shift_unit_step.sv
// One-bit shift of a WIDTH-bit word.
// Purely combinational; mode selects the fill/rotate behaviour.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] y
);

  // single-position shift selected by mode
  always_comb begin
    y = x;
    unique case (mode)
      SH_ASR: y = {x[WIDTH-1], x[WIDTH-1:1]};
      SH_LSR: y = {1'b0, x[WIDTH-1:1]};
      SH_LSL: y = {x[WIDTH-2:0], 1'b0};
      SH_ROR: y = {x[0], x[WIDTH-1:1]};
      default: y = x;
    endcase
  end

endmodule

// File: rtl/multi_mode_shift_unit.sv
// Multi-cycle variable-distance shifter, one bit per clock.
// start/busy/done handshake; accepts a new op in IDLE or DONE.
module multi_mode_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  shift_mode_t      mode_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] nxt;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .x    (out),
    .mode (mode_q),
    .y    (nxt)
  );

  // control FSM, down-counter and data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= SH_ASR;
      cnt    <= '0;
      out    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          out <= nxt;
          cnt <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            out    <= in;
            cnt    <= amount;
            mode_q <= shift_mode_t'(mode);
            if (amount != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_mode_shift_unit.sv
// Directed bench for multi_mode_shift_unit.
// Hand-computed vectors plus a small sweep vs a shift-operator model.
module tb_multi_mode_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic [3:0]  amount;
  logic [1:0]  mode;
  logic [15:0] dout;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  multi_mode_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in     (din),
    .amount (amount),
    .mode   (mode),
    .out    (dout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at the negedge after the accepting edge
  task automatic wait_done(input int poke,
                           output int lat,
                           output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
      if (lat == poke) begin
        start  = 1'b1;
        din    = 16'hFFFF;
        amount = 4'd0;
      end else begin
        start  = 1'b0;
        din    = 16'($urandom);
        amount = 4'($urandom);
        mode   = 2'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic op(input string tag,
                    input bit b2b,
                    input logic [15:0] a,
                    input logic [3:0] n,
                    input logic [1:0] m,
                    input logic [15:0] exp,
                    input int poke);
    int lat;
    int bcnt;
    if (!b2b) @(negedge clk);
    start  = 1'b1;
    din    = a;
    amount = n;
    mode   = m;
    @(negedge clk);
    start  = 1'b0;
    din    = ~a;
    amount = ~n;
    mode   = ~m;
    wait_done(poke, lat, bcnt);
    check({tag, " out"}, 32'(dout), 32'(exp));
    check({tag, " lat"}, lat, 32'(n) + 1);
    check({tag, " busy"}, bcnt, 32'(n));
  endtask

  function automatic logic [15:0] model(input logic [15:0] a,
                                        input logic [3:0] n,
                                        input logic [1:0] m);
    logic [31:0] r;
    case (m)
      2'b00: return 16'($signed(a) >>> n);
      2'b01: return a >> n;
      2'b10: return a << n;
      default: begin
        r = {a, a} >> n;
        return r[15:0];
      end
    endcase
  endfunction

  initial begin
    int cnt;
    logic [15:0] a;
    logic [3:0]  n;
    logic [1:0]  m;
    n_tests = 0;
    n_fail  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    din    = '0;
    amount = '0;
    mode   = '0;
    @(negedge clk);
    check("rst out", 32'(dout), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst done", 32'(done), 32'h0);
    rst_n = 1'b1;

    op("asr3", 0, 16'h8000, 4'd3, 2'b00, 16'hF000, 0);
    @(negedge clk);
    check("done pulse", 32'(done), 32'h0);
    op("lsr3", 0, 16'h8000, 4'd3, 2'b01, 16'h1000, 0);
    op("lsl15", 0, 16'h0001, 4'd15, 2'b10, 16'h8000, 0);
    op("ror1", 0, 16'h0001, 4'd1, 2'b11, 16'h8000, 0);
    op("ror4", 0, 16'h1234, 4'd4, 2'b11, 16'h4123, 0);
    op("zero asr", 0, 16'h1234, 4'd0, 2'b00, 16'h1234, 0);
    op("zero ror", 0, 16'hA5A5, 4'd0, 2'b11, 16'hA5A5, 0);
    op("asr15 pos", 0, 16'h7FFF, 4'd15, 2'b00, 16'h0000, 0);
    op("asr15 neg", 0, 16'h8001, 4'd15, 2'b00, 16'hFFFF, 0);
    op("lsl8", 0, 16'h00FF, 4'd8, 2'b10, 16'hFF00, 0);
    op("lsr15", 0, 16'h8421, 4'd15, 2'b01, 16'h0001, 0);

    op("busy start", 0, 16'h8000, 4'd6, 2'b00, 16'hFE00, 3);
    op("b2b first", 0, 16'h8000, 4'd3, 2'b00, 16'hF000, 0);
    op("b2b second", 1, 16'h0003, 4'd2, 2'b10, 16'h000C, 0);

    @(negedge clk);
    start  = 1'b1;
    din    = 16'hBEEF;
    amount = 4'd10;
    mode   = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst out", 32'(dout), 32'h0);
    check("arst busy", 32'(busy), 32'h0);
    check("arst done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("no done after rst", cnt, 0);
    op("post rst", 0, 16'h00F0, 4'd4, 2'b01, 16'h000F, 0);

    repeat (30) begin
      a = 16'($urandom);
      n = 4'($urandom);
      m = 2'($urandom);
      op("sweep", 0, a, n, m, model(a, n, m), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
